// File: rtl/pic_nested.sv
// Nested-priority interrupt controller: pending/in-service/mask registers, EOI handling,
// per-line edge or level triggering and a vector returned one cycle after acknowledge.
module pic_nested #(
  parameter int unsigned NUM_IRQ    = 8,
  parameter logic [7:0]  VEC_BASE   = 8'h08,
  parameter logic [7:0]  LEVEL_MASK = 8'h00
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [NUM_IRQ-1:0] iIrq,
  input  logic               iIntAck,
  output logic               oInt,
  output logic               oSel,
  output logic [7:0]         oData,
  input  logic               iIoWr,
  input  logic               iIoRd,
  input  logic               iIoAddr,
  input  logic [7:0]         iIoData,
  output logic [7:0]         oIoData
);

  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [NUM_IRQ-1:0] irqd_q;
  logic [7:0]         vec_q, vec_d;
  logic               sel_q;

  logic [NUM_IRQ-1:0] elig;
  logic               has_e, has_s;
  logic [2:0]         p_idx, s_idx;
  logic               int_req;

  // Priority encoders: lowest set index wins.
  always_comb begin
    elig  = irr_q & ~imr_q;
    has_e = 1'b0;
    p_idx = 3'd0;
    has_s = 1'b0;
    s_idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        has_e = 1'b1;
        p_idx = 3'(i);
      end
      if (isr_q[i]) begin
        has_s = 1'b1;
        s_idx = 3'(i);
      end
    end
    int_req = has_e && (!has_s || (p_idx < s_idx));
  end

  always_comb begin
    irr_d = irr_q;
    isr_d = isr_q;
    imr_d = imr_q;
    vec_d = vec_q;

    for (int k = 0; k < NUM_IRQ; k++) begin
      if (LEVEL_MASK[k]) begin
        irr_d[k] = iIrq[k];
      end else begin
        if (iIntAck && int_req && (p_idx == 3'(k))) irr_d[k] = 1'b0;
        // A fresh edge beats the acknowledge clear.
        if (iIrq[k] && !irqd_q[k]) irr_d[k] = 1'b1;
      end
    end

    if (iIoWr && !iIoAddr) begin
      if (iIoData == 8'h20) begin
        if (has_s) isr_d[s_idx] = 1'b0;
      end else if ((iIoData[7:3] == 5'b01100) && (32'(iIoData[2:0]) < NUM_IRQ)) begin
        isr_d[iIoData[2:0]] = 1'b0;
      end
    end

    if (iIoWr && iIoAddr) imr_d = iIoData[NUM_IRQ-1:0];

    // Acknowledge applied last so its in-service set overrides a same-cycle EOI.
    if (iIntAck) begin
      if (int_req) begin
        isr_d[p_idx] = 1'b1;
        vec_d        = VEC_BASE + 8'(p_idx);
      end else begin
        vec_d        = VEC_BASE + 8'(NUM_IRQ - 1);
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      irr_q  <= '0;
      isr_q  <= '0;
      imr_q  <= '0;
      irqd_q <= '0;
      vec_q  <= 8'h00;
      sel_q  <= 1'b0;
    end else begin
      irr_q  <= irr_d;
      isr_q  <= isr_d;
      imr_q  <= imr_d;
      irqd_q <= iIrq;
      vec_q  <= vec_d;
      sel_q  <= iIntAck;
    end
  end

  always_comb begin
    oIoData = 8'h00;
    if (iIoRd) oIoData = iIoAddr ? 8'(imr_q) : 8'(isr_q);
  end

  assign oInt  = int_req;
  assign oSel  = sel_q;
  assign oData = vec_q;

endmodule
